// File: rtl/decode_pkg.sv
// Shared decode constants and the registered decode bundle handed to execute.
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] valt;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  sa;
    logic [4:0]  dst;
  } dec_bundle_t;

endpackage

// File: rtl/decode_fwd_mux.sv
// One operand's forwarding network: nearest matching producer wins, $0 is hard zero.
module decode_fwd_mux #(
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]                idx,
  input  logic [31:0]               rf_val,
  input  logic [NUM_FWD-1:0][4:0]   fwd_dst,
  input  logic [NUM_FWD-1:0][31:0]  fwd_val,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  output logic [31:0]               val,
  output logic                      not_rdy
);

  // Walk oldest to nearest so the lowest-index match overwrites last.
  always_comb begin
    val     = rf_val;
    not_rdy = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_dst[i] == idx) begin
        val     = fwd_val[i];
        not_rdy = !fwd_rdy[i];
      end
    end
    if (idx == 5'd0) begin
      val     = '0;
      not_rdy = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// Registered MIPS decode with operand forwarding, load-use stall and branch redirect.
// Define DECODE_REGIMM_EN to decode BLTZ/BGEZ; otherwise REGIMM is a no-op.
module decode_stage_fwd
  import decode_pkg::*;
#(
  parameter int NUM_FWD     = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_instr,
  input  logic [31:0]               in_link,
  input  logic                      flush,
  output logic [4:0]                rf_idx1,
  output logic [4:0]                rf_idx2,
  input  logic [31:0]               rf_val1,
  input  logic [31:0]               rf_val2,
  input  logic [NUM_FWD-1:0][4:0]   fwd_dst,
  input  logic [NUM_FWD-1:0][31:0]  fwd_val,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_val1,
  output logic [31:0]               out_val2,
  output logic [31:0]               out_valt,
  output logic [5:0]                out_op,
  output logic [5:0]                out_funct,
  output logic [4:0]                out_sa,
  output logic [4:0]                out_dst,
  output logic                      redirect,
  output logic [31:0]               redirect_pc,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign sa    = in_instr[10:6];
  assign funct = in_instr[5:0];
  assign imm   = in_instr[15:0];

  assign rf_idx1 = rs;
  assign rf_idx2 = rt;

  // Operand 0 is rs, operand 1 is rt.
  logic [1:0][4:0]  src_idx;
  logic [1:0][31:0] src_rf, src_val;
  logic [1:0]       src_busy;

  assign src_idx = {rt, rs};
  assign src_rf  = {rf_val2, rf_val1};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      decode_fwd_mux #(.NUM_FWD(NUM_FWD)) u_mux (
        .idx     (src_idx[g]),
        .rf_val  (src_rf[g]),
        .fwd_dst (fwd_dst),
        .fwd_val (fwd_val),
        .fwd_rdy (fwd_rdy),
        .val     (src_val[g]),
        .not_rdy (src_busy[g])
      );
    end
  endgenerate

  logic [31:0] rs_v, rt_v;
  logic        rs_neg, rs_zero;
  assign rs_v    = src_val[0];
  assign rt_v    = src_val[1];
  assign rs_neg  = rs_v[31];
  assign rs_zero = (rs_v == 32'd0);

  logic [31:0] pc4, sext, br_tgt, j_tgt;
  assign pc4    = in_pc + 32'd4;
  assign sext   = {{16{imm[15]}}, imm};
  assign br_tgt = pc4 + {sext[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], in_instr[25:0], 2'b00};

  logic        is_shift;
  assign is_shift = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);

  logic        use_rs, use_rt, imm_b, imm_zx, imm_lui, a_link, a_zero, taken;
  logic [4:0]  dst;
  logic [31:0] tgt;

  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    imm_b   = 1'b1;
    imm_zx  = 1'b0;
    imm_lui = 1'b0;
    a_link  = 1'b0;
    a_zero  = 1'b0;
    taken   = 1'b0;
    dst     = '0;
    tgt     = br_tgt;
    case (op)
      OP_SPECIAL: begin
        imm_b  = 1'b0;
        use_rs = !is_shift;
        use_rt = 1'b1;
        dst    = rd;
        if (funct == FN_JR || funct == FN_JALR) begin
          use_rt = 1'b0;
          taken  = 1'b1;
          tgt    = rs_v;
          a_link = (funct == FN_JALR);
          if (funct == FN_JR) dst = '0;
        end
      end
      OP_J: begin
        taken  = 1'b1;
        tgt    = j_tgt;
        a_zero = 1'b1;
      end
      OP_JAL: begin
        taken  = 1'b1;
        tgt    = j_tgt;
        a_link = 1'b1;
        dst    = 5'd31;
      end
      OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        taken  = (rs_v == rt_v);
      end
      OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        taken  = (rs_v != rt_v);
      end
      OP_BLEZ: begin
        use_rs = 1'b1;
        taken  = rs_neg || rs_zero;
      end
      OP_BGTZ: begin
        use_rs = 1'b1;
        taken  = !rs_neg && !rs_zero;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        use_rs = 1'b1;
        dst    = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        use_rs = 1'b1;
        dst    = rt;
        imm_zx = 1'b1;
      end
      OP_LUI: begin
        dst     = rt;
        imm_lui = 1'b1;
        a_zero  = 1'b1;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
`ifdef DECODE_REGIMM_EN
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          use_rs = 1'b1;
          taken  = rs_neg;
        end else if (rt == RT_BGEZ) begin
          use_rs = 1'b1;
          taken  = !rs_neg;
        end
      end
`endif
      default: ;
    endcase
  end

  logic hazard, xfer;
  assign hazard   = (use_rs && src_busy[0]) || (use_rt && src_busy[1]);
  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  logic [31:0] imm_v;
  dec_bundle_t dec, bun_q;

  assign imm_v = imm_lui ? {imm, 16'h0000} : (imm_zx ? {16'h0000, imm} : sext);

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.val1  = a_link ? in_link : (a_zero ? 32'd0 : rs_v);
    dec.val2  = imm_b ? imm_v : rt_v;
    dec.valt  = rt_v;
    dec.op    = op;
    dec.funct = funct;
    dec.sa    = sa;
    dec.dst   = dst;
  end

  // Flush overrides both a new transfer and the consume of the held bundle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      bun_q       <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        redirect  <= 1'b0;
      end else if (xfer) begin
        out_valid   <= 1'b1;
        bun_q       <= dec;
        redirect    <= taken;
        redirect_pc <= tgt;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        redirect <= 1'b0;
      end
      if (in_valid && hazard && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_pc    = bun_q.pc;
  assign out_val1  = bun_q.val1;
  assign out_val2  = bun_q.val2;
  assign out_valt  = bun_q.valt;
  assign out_op    = bun_q.op;
  assign out_funct = bun_q.funct;
  assign out_sa    = bun_q.sa;
  assign out_dst   = bun_q.dst;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed plus random stimulus for decode_stage_fwd against a cycle-level reference model.
module tb_decode_stage_fwd;

  localparam int NF = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic in_valid, in_ready, flush, out_valid, out_ready, redirect;
  logic [31:0] in_pc, in_instr, in_link, rf_val1, rf_val2;
  logic [4:0]  rf_idx1, rf_idx2, out_sa, out_dst;
  logic [NF-1:0][4:0]  fwd_dst;
  logic [NF-1:0][31:0] fwd_val;
  logic [NF-1:0]       fwd_rdy;
  logic [31:0] out_pc, out_val1, out_val2, out_valt, redirect_pc;
  logic [5:0]  out_op, out_funct;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage_fwd #(.NUM_FWD(NF), .STALL_CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_link(in_link), .flush(flush),
    .rf_idx1(rf_idx1), .rf_idx2(rf_idx2), .rf_val1(rf_val1), .rf_val2(rf_val2),
    .fwd_dst(fwd_dst), .fwd_val(fwd_val), .fwd_rdy(fwd_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_val1(out_val1), .out_val2(out_val2), .out_valt(out_valt),
    .out_op(out_op), .out_funct(out_funct), .out_sa(out_sa), .out_dst(out_dst),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] pc, v1, v2, vt;
    logic [5:0]  op, fn;
    logic [4:0]  sa, dst;
  } bun_t;

  bun_t        e_b, m_b;
  bit          e_hz, e_rdy, e_tk, m_v, m_red;
  logic [31:0] e_tgt, m_rpc;
  int          m_cnt;
  int          n_chk = 0;
  int          n_bad = 0;

  logic [5:0] op_tab [0:18] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
  logic [5:0] fn_tab [0:9]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Register value as seen through the forwarding network: first match from stage 0 up.
  task automatic fwd(input logic [4:0] r, input logic [31:0] rfv, output logic [31:0] v, output bit busy);
    v = rfv;
    busy = 0;
    if (r != 5'd0) begin
      for (int i = 0; i < NF; i++) begin
        if (fwd_dst[i] == r) begin
          v = fwd_val[i];
          busy = !fwd_rdy[i];
          break;
        end
      end
    end else v = 32'd0;
  endtask

  task automatic model_comb();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, sx, zx, pc4, btgt;
    bit ba, bb, ur, ut, isr, shf, jr, jalr, regimm;
    op = in_instr[31:26]; rs = in_instr[25:21]; rt = in_instr[20:16];
    rd = in_instr[15:11]; fn = in_instr[5:0];
    fwd(rs, rf_val1, a, ba);
    fwd(rt, rf_val2, b, bb);
    sx   = {{16{in_instr[15]}}, in_instr[15:0]};
    zx   = {16'h0, in_instr[15:0]};
    pc4  = in_pc + 32'd4;
    btgt = pc4 + sx * 4;
    isr  = (op == 6'h00);
    shf  = isr && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
    jr   = isr && fn == 6'h08;
    jalr = isr && fn == 6'h09;
`ifdef DECODE_REGIMM_EN
    regimm = (op == 6'h01) && (rt < 5'd2);
`else
    regimm = 0;
`endif
    ur = !(op inside {6'h02, 6'h03, 6'h0f}) && !shf && (op != 6'h01 || regimm);
    ut = (isr && !jr && !jalr) || (op inside {6'h04, 6'h05, 6'h2b});
    e_hz  = (ur && ba) || (ut && bb);
    e_rdy = !e_hz && !flush && (!m_v || out_ready);

    e_b.pc = in_pc; e_b.op = op; e_b.fn = fn; e_b.sa = in_instr[10:6]; e_b.vt = b;
    if (isr) e_b.dst = jr ? 5'd0 : rd;
    else if (op == 6'h03) e_b.dst = 5'd31;
    else if (op inside {6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23}) e_b.dst = rt;
    else e_b.dst = 5'd0;
    if (isr) e_b.v2 = b;
    else if (op inside {6'h0c, 6'h0d, 6'h0e}) e_b.v2 = zx;
    else if (op == 6'h0f) e_b.v2 = zx << 16;
    else e_b.v2 = sx;
    if (op == 6'h03 || jalr) e_b.v1 = in_link;
    else if (op inside {6'h02, 6'h0f}) e_b.v1 = 32'd0;
    else e_b.v1 = a;

    e_tk = 0; e_tgt = btgt;
    case (op)
      6'h00: begin e_tk = jr || jalr; e_tgt = a; end
      6'h02, 6'h03: begin
        e_tk = 1;
        e_tgt = (pc4 & 32'hF000_0000) | ({6'h0, in_instr[25:0]} * 4);
      end
      6'h04: e_tk = (a == b);
      6'h05: e_tk = (a != b);
      6'h06: e_tk = ($signed(a) <= 0);
      6'h07: e_tk = ($signed(a) > 0);
      6'h01: e_tk = regimm && ((rt == 5'd0) ? ($signed(a) < 0) : ($signed(a) >= 0));
      default: ;
    endcase
  endtask

  task automatic check_regs();
    chk("out_valid", out_valid, m_v);
    if (m_v) begin
      chk("out_pc", out_pc, m_b.pc);
      chk("out_val1", out_val1, m_b.v1);
      chk("out_val2", out_val2, m_b.v2);
      chk("out_valt", out_valt, m_b.vt);
      chk("out_op", out_op, m_b.op);
      chk("out_funct", out_funct, m_b.fn);
      chk("out_sa", out_sa, m_b.sa);
      chk("out_dst", out_dst, m_b.dst);
    end
    chk("redirect", redirect, m_red);
    if (m_red) chk("redirect_pc", redirect_pc, m_rpc);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // One clock: check at negedge, advance the model on posedge, return 1 unit after it.
  task automatic step();
    @(negedge clk);
    model_comb();
    chk("in_ready", in_ready, e_rdy);
    chk("rf_idx1", rf_idx1, in_instr[25:21]);
    chk("rf_idx2", rf_idx2, in_instr[20:16]);
    check_regs();
    @(posedge clk);
    if (in_valid && e_hz && !flush && m_cnt != CMAX) m_cnt++;
    if (flush) begin
      m_v = 0; m_red = 0;
    end else if (in_valid && e_rdy) begin
      m_v = 1; m_b = e_b; m_red = e_tk; m_rpc = e_tgt;
    end else begin
      if (out_ready) m_v = 0;
      m_red = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    m_v = 0; m_red = 0; m_cnt = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_val1", out_val1, 0);
    chk("rst_val2", out_val2, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_rpc", redirect_pc, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; out_ready = 1;
    in_pc = 0; in_instr = 0; in_link = 0; rf_val1 = 0; rf_val2 = 0;
    fwd_dst = '0; fwd_val = '0; fwd_rdy = '1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] r;
    op = op_tab[$urandom_range(0, 18)];
    fn = fn_tab[$urandom_range(0, 9)];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    r  = $urandom;
    sa = r[10:6];
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h09) rt = 5'd0;
      return {op, rs, rt, rd, sa, fn};
    end
    if (op == 6'h02 || op == 6'h03) return {op, r[25:0]};
    if (op == 6'h01) rt = 5'($urandom_range(0, 2));
    return {op, rs, rt, r[15:0]};
  endfunction

  task automatic rand_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 11) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    in_pc     = $urandom & 32'hFFFF_FFFC;
    in_link   = in_pc + 32'd8;
    in_instr  = gen_instr();
    rf_val1   = pick();
    rf_val2   = ($urandom_range(0, 1) != 0) ? rf_val1 : pick();
    for (int i = 0; i < NF; i++) begin
      fwd_dst[i] = 5'($urandom_range(0, 7));
      fwd_val[i] = pick();
      fwd_rdy[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    set_idle();
    #1;
    do_reset();

    // ADDIU $2,$0,-1
    in_valid = 1; in_pc = 32'h40; rf_val1 = 32'h1234;
    in_instr = {6'h09, 5'd0, 5'd2, 16'hFFFF};
    step();
    chk("addiu_valid", out_valid, 1);
    chk("addiu_dst", out_dst, 2);
    chk("addiu_val2", out_val2, 32'hFFFF_FFFF);
    chk("addiu_val1", out_val1, 0);

    // ADDU $3,$1,$2 with both operands forwarded
    in_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    fwd_dst[0] = 5'd1; fwd_val[0] = 32'd5;
    fwd_dst[1] = 5'd2; fwd_val[1] = 32'd7;
    rf_val1 = 32'd99; rf_val2 = 32'd98;
    step();
    chk("addu_val1", out_val1, 5);
    chk("addu_val2", out_val2, 7);
    chk("addu_dst", out_dst, 3);

    // Load-use on rs=4; an older ready match must not hide the stall
    set_idle();
    step();
    do_reset();
    in_valid = 1; in_pc = 32'h80;
    in_instr = {6'h09, 5'd4, 5'd5, 16'h0001};
    fwd_dst[0] = 5'd4; fwd_dst[1] = 5'd4; fwd_rdy = 3'b110;
    #1;
    chk("lu_ready0", in_ready, 0);
    step();
    chk("lu_ready1", in_ready, 0);
    step();
    chk("lu_cnt", stall_cnt, 2);
    chk("lu_valid_hold", out_valid, 0);
    fwd_rdy = '1;
    step();
    chk("lu_accept", out_valid, 1);
    chk("lu_dst", out_dst, 5);

    // Taken BEQ at 0x100 then its delay slot
    in_pc = 32'h100; in_instr = {6'h04, 5'd1, 5'd2, 16'h0003};
    fwd_dst[0] = 5'd1; fwd_dst[1] = 5'd2; fwd_val[0] = 32'd9; fwd_val[1] = 32'd9;
    step();
    chk("beq_redirect", redirect, 1);
    chk("beq_target", redirect_pc, 32'h110);
    in_pc = 32'h104; in_instr = {6'h09, 5'd0, 5'd6, 16'h0001}; fwd_dst = '0;
    step();
    chk("slot_redirect", redirect, 0);
    chk("slot_valid", out_valid, 1);
    chk("slot_pc", out_pc, 32'h104);

    // Flush against a pending JAL, then the JAL goes through
    in_pc = 32'h108; in_link = 32'h110; in_instr = {6'h03, 26'h000_0040}; flush = 1;
    #1;
    chk("flush_ready", in_ready, 0);
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_redirect", redirect, 0);
    flush = 0;
    step();
    chk("jal_pc", out_pc, 32'h108);
    chk("jal_dst", out_dst, 31);
    chk("jal_link", out_val1, 32'h110);
    chk("jal_redirect", redirect, 1);
    chk("jal_target", redirect_pc, 32'h100);

    // BLTZ with rs=-1
    in_pc = 32'h200; in_instr = {6'h01, 5'd3, 5'd0, 16'h0010};
    fwd_dst[0] = 5'd3; fwd_val[0] = 32'hFFFF_FFFF;
    step();
`ifdef DECODE_REGIMM_EN
    chk("bltz_redirect", redirect, 1);
    chk("bltz_target", redirect_pc, 32'h244);
`else
    chk("bltz_redirect", redirect, 0);
    chk("bltz_dst", out_dst, 0);
`endif

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step();
    end

    // Async reset in the middle of a stall
    set_idle();
    in_valid = 1; in_instr = {6'h09, 5'd4, 5'd5, 16'h0001};
    fwd_dst[0] = 5'd4; fwd_rdy = 3'b110;
    step();
    step();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
